// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

  // One-bit state encoding: IDLE waits for start, SHIFT processes one bit per clock.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  // Counter width for WIDTH bit positions; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Gate-level full subtractor: x - y - bin.
// Ports:
//   x, y  - minuend and subtrahend bits
//   bin   - incoming borrow
//   d     - difference bit
//   bout  - outgoing borrow
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  // First half-subtractor stage: x - y.
  assign hs1_d = x ^ y;
  assign hs1_b = ~x & y;

  // Second half-subtractor stage: (x - y) - bin.
  assign d     = hs1_d ^ bin;
  assign hs2_b = ~hs1_d & bin;

  assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing a - b one bit per clock, LSB first, with a
// registered borrow. A start/busy/done handshake frames each operation.
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   start      - request, sampled only while idle
//   a, b       - minuend and subtrahend, captured on the accepting edge
//   busy       - high while bits are being shifted
//   done       - one-cycle pulse when diff/bout/ovf become valid
//   diff       - a - b modulo 2^WIDTH, held until the next accepted start
//   bout       - final borrow (a < b unsigned)
//   ovf        - two's-complement overflow of a - b
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             done_q, done_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             cell_d;
  logic             cell_b;
  logic [WIDTH-1:0] diff_shift;

  // Single serial bit cell operating on the current LSBs and stored borrow.
  full_subtractor u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_b)
  );

  // New difference bit enters at the MSB so the result lands LSB-aligned.
  if (WIDTH == 1) begin : g_shift_w1
    assign diff_shift = cell_d;
  end else begin : g_shift_wn
    assign diff_shift = {cell_d, diff_q[WIDTH-1:1]};
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      diff_q  <= '0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      diff_q  <= diff_d;
      done_q  <= done_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    diff_d  = diff_q;
    done_d  = 1'b0;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        diff_d = diff_shift;
        br_d   = cell_b;
        sa_d   = sa_q >> 1;
        sb_d   = sb_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          bout_d  = cell_b;
          // Overflow only when operand signs differ and the result sign leaves a's sign.
          ovf_d   = (amsb_q != bmsb_q) && (cell_d != amsb_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_SHIFT);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start8, start1;
  logic [W-1:0] a8, b8;
  logic [0:0]   a1, b1;
  logic         busy8, done8, bout8, ovf8;
  logic [W-1:0] diff8;
  logic         busy1, done1, bout1, ovf1;
  logic [0:0]   diff1;

  int n_tests;
  int n_fail;
  int cyc;
  exp_t sb_q[$];

  serial_subtractor #(.WIDTH(W)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model built from integer arithmetic, independent of the bit-serial form.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   sa, sb, sd;
    sa = $signed(a);
    sb = $signed(b);
    sd = sa - sb;
    e.diff = W'(a - b);
    e.bout = (a < b);
    e.ovf  = (sd > 127) || (sd < -128);
    e.acc_cyc = 0;
    return e;
  endfunction

  // Scoreboard: every done pulse pops and checks one expected result.
  always @(negedge clk) begin
    if (done8) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done8), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("diff", 32'(diff8), 32'(e.diff));
        check("bout", 32'(bout8), 32'(e.bout));
        check("ovf", 32'(ovf8), 32'(e.ovf));
        check("latency", 32'(cyc - e.acc_cyc), 32'(W));
      end
    end
  end

  // Issue one operation on the 8-bit instance and follow busy until done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ed, input logic eb, input logic eo);
    exp_t e;
    logic busy_ok;
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    e.diff = ed;
    e.bout = eb;
    e.ovf = eo;
    e.acc_cyc = cyc;
    sb_q.push_back(e);
    busy_ok = busy8;
    for (int i = 1; i < int'(W); i++) begin
      tick();
      busy_ok = busy_ok & busy8 & ~done8;
    end
    check("busy_window", 32'(busy_ok), 32'd1);
    tick();
    check("busy_fall", 32'(busy8), 32'd0);
    check("done_pulse", 32'(done8), 32'd1);
  endtask

  task automatic wait_done8(input int budget);
    int n;
    n = 0;
    while (!done8 && n < budget) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(done8), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    exp_t m;
    logic [W-1:0] ra, rb;
    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    rst_n = 1'b0;
    start8 = 1'b0;
    start1 = 1'b0;
    a8 = '0;
    b8 = '0;
    a1 = '0;
    b1 = '0;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};

    #12;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_bout", 32'(bout8), 32'd0);
    check("rst_ovf", 32'(ovf8), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed table.
    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout, vecs[i].ovf);

    // Random operands against the integer model.
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      m = model(ra, rb);
      do_op(ra, rb, m.diff, m.bout, m.ovf);
    end

    // Start during busy is ignored; start in the done cycle is accepted.
    a8 = 8'h10;
    b8 = 8'h01;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    m = model(8'h10, 8'h01);
    m.acc_cyc = cyc;
    sb_q.push_back(m);
    tick();
    tick();
    a8 = 8'hFF;
    b8 = 8'hFF;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("busy_ignore", 32'(busy8), 32'd1);
    wait_done8(20);
    check("hs_diff_0f", 32'(diff8), 32'h0F);
    a8 = 8'h00;
    b8 = 8'h00;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("b2b_accept", 32'(busy8), 32'd1);
    m = model(8'h00, 8'h00);
    m.acc_cyc = cyc;
    sb_q.push_back(m);
    wait_done8(20);
    tick();
    check("done_clears", 32'(done8), 32'd0);
    check("diff_held", 32'(diff8), 32'h00);

    // Reset in mid-operation aborts with no done.
    a8 = 8'hAA;
    b8 = 8'h55;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy8), 32'd0);
    check("mid_rst_done", 32'(done8), 32'd0);
    check("mid_rst_diff", 32'(diff8), 32'd0);
    check("mid_rst_bout", 32'(bout8), 32'd0);
    check("mid_rst_ovf", 32'(ovf8), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    do_op(8'hAA, 8'h55, 8'h55, 1'b0, 1'b1);
    tick();
    check("queue_empty", 32'(sb_q.size()), 32'd0);

    // One-bit instance: 0 - (-1) = +1 does not fit in one signed bit.
    a1 = 1'b0;
    b1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("w1_busy", 32'(busy1), 32'd1);
    check("w1_not_done", 32'(done1), 32'd0);
    tick();
    check("w1_done", 32'(done1), 32'd1);
    check("w1_busy_fall", 32'(busy1), 32'd0);
    check("w1_diff", 32'(diff1), 32'd1);
    check("w1_bout", 32'(bout1), 32'd1);
    check("w1_ovf", 32'(ovf1), 32'd1);
    a1 = 1'b1;
    b1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    check("w1b_done", 32'(done1), 32'd1);
    check("w1b_diff", 32'(diff1), 32'd1);
    check("w1b_bout", 32'(bout1), 32'd0);
    check("w1b_ovf", 32'(ovf1), 32'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
